// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in the EXE stage.
// Stalls the pipeline while busy and presents a registered result for one cycle.
module div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            exe_div_valid,
  input  logic [1:0]      exe_op,
  input  logic [XLEN-1:0] exe_rs1,
  input  logic [XLEN-1:0] exe_rs2,
  input  logic            abort,
  output logic            div_running,
  output logic            div_done,
  output logic [XLEN-1:0] div_result,
  output logic [1:0]      div_status
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [1:0]        op_reg, op_next;
  logic [XLEN-1:0]   divisor_reg, divisor_next;
  logic [XLEN-1:0]   rem_reg, rem_next;
  logic [XLEN-1:0]   quot_reg, quot_next;
  logic              q_neg_reg, q_neg_next;
  logic              r_neg_reg, r_neg_next;
  logic [XLEN-1:0]   result_reg, result_next;

  // Operand conditioning for a new instruction.
  logic              start_signed;
  logic              start_rem;
  logic [XLEN-1:0]   rs1_abs;
  logic [XLEN-1:0]   rs2_abs;
  logic              div_by_zero;
  logic              signed_ovf;

  // One restoring iteration on the current partial remainder/quotient.
  logic [XLEN:0]     rem_shift;
  logic [XLEN:0]     trial;
  logic              trial_ok;
  logic [XLEN-1:0]   rem_step;
  logic [XLEN-1:0]   quot_step;
  logic              fix_sign;
  logic [XLEN-1:0]   q_final;
  logic [XLEN-1:0]   r_final;

  always_comb begin
    start_signed = ~exe_op[0];
    start_rem    = exe_op[1];
    // Negating INT_MIN yields INT_MIN, which is still the right unsigned magnitude.
    rs1_abs      = (start_signed && exe_rs1[XLEN-1]) ? (~exe_rs1 + 1'b1) : exe_rs1;
    rs2_abs      = (start_signed && exe_rs2[XLEN-1]) ? (~exe_rs2 + 1'b1) : exe_rs2;
    div_by_zero  = (exe_rs2 == '0);
    signed_ovf   = start_signed && (exe_rs1 == INT_MIN) && (exe_rs2 == ALL_ONES);
  end

  always_comb begin
    rem_shift = {rem_reg, quot_reg[XLEN-1]};
    trial     = rem_shift - {1'b0, divisor_reg};
    trial_ok  = ~trial[XLEN];
    rem_step  = trial_ok ? trial[XLEN-1:0] : rem_shift[XLEN-1:0];
    quot_step = {quot_reg[XLEN-2:0], trial_ok};
    fix_sign  = ~op_reg[0];
    q_final   = (fix_sign && q_neg_reg) ? (~quot_step + 1'b1) : quot_step;
    r_final   = (fix_sign && r_neg_reg) ? (~rem_step + 1'b1) : rem_step;
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    op_next      = op_reg;
    divisor_next = divisor_reg;
    rem_next     = rem_reg;
    quot_next    = quot_reg;
    q_neg_next   = q_neg_reg;
    r_neg_next   = r_neg_reg;
    result_next  = result_reg;
    div_running  = 1'b0;
    div_done     = 1'b0;

    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (exe_div_valid) begin
            div_running = 1'b1;
            op_next     = exe_op;
            if (div_by_zero) begin
              state_next  = DONE;
              result_next = start_rem ? exe_rs1 : ALL_ONES;
            end else if (signed_ovf) begin
              state_next  = DONE;
              result_next = start_rem ? '0 : INT_MIN;
            end else begin
              state_next   = BUSY;
              cnt_next     = '0;
              rem_next     = '0;
              quot_next    = rs1_abs;
              divisor_next = rs2_abs;
              q_neg_next   = start_signed && (exe_rs1[XLEN-1] ^ exe_rs2[XLEN-1]);
              r_neg_next   = start_signed && exe_rs1[XLEN-1];
            end
          end
        end

        BUSY: begin
          div_running = 1'b1;
          rem_next    = rem_step;
          quot_next   = quot_step;
          cnt_next    = cnt_reg + 1'b1;
          if (cnt_reg == LAST_CNT) begin
            state_next  = DONE;
            cnt_next    = '0;
            result_next = op_reg[1] ? r_final : q_final;
          end
        end

        DONE: begin
          // The instruction leaves EXE on this edge, so a still-high valid is not a new start.
          div_done   = 1'b1;
          state_next = IDLE;
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      op_reg      <= '0;
      divisor_reg <= '0;
      rem_reg     <= '0;
      quot_reg    <= '0;
      q_neg_reg   <= 1'b0;
      r_neg_reg   <= 1'b0;
      result_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      op_reg      <= op_next;
      divisor_reg <= divisor_next;
      rem_reg     <= rem_next;
      quot_reg    <= quot_next;
      q_neg_reg   <= q_neg_next;
      r_neg_reg   <= r_neg_next;
      result_reg  <= result_next;
    end
  end

  assign div_result = result_reg;
  assign div_status = state_reg;

endmodule
